inst_template_emitter: RTL and testbench



---
 rtl/jit_pkg.sv | 38 +++
 rtl/inst_template_rom.sv | 25 ++
 rtl/inst_template_emitter.sv | 184 ++++++++++++++++++
 tb/tb_inst_template_emitter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jit_pkg.sv
// jit_pkg: types and constants shared by the JIT translate path
// (opcode address lookup, template ROM, template emitter).
package jit_pkg;

    localparam int ADR_W   = 7;
    localparam int WORD_W  = 32;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // One template ROM entry: {patch, last, word}
    typedef struct packed {
        logic              patch;
        logic              last;
        logic [WORD_W-1:0] word;
    } tmpl_entry_t;

    // Replace the immediate field of a template word with the operand when enabled
    function automatic logic [WORD_W-1:0] patch_imm(
        input logic [WORD_W-1:0] word,
        input logic [IMM_W-1:0]  imm,
        input logic              en
    );
        logic [WORD_W-1:0] res;
        res = word;
        if (en) begin
            res[IMM_LSB +: IMM_W] = imm;
        end else begin
            res = word;
        end
        return res;
    endfunction

endpackage

// File: rtl/inst_template_rom.sv
// inst_template_rom: combinational ARM template image, indexed by
// template address. Contents come from the template ROM generator;
// this image holds the templates currently in use.
module inst_template_rom
    import jit_pkg::*;
(
    input  logic [ADR_W-1:0] adr,
    output tmpl_entry_t      entry
);

    // Address-to-entry lookup; unlisted addresses read as an empty entry
    always_comb begin
        entry = '{patch: 1'b0, last: 1'b0, word: 32'h0000_0000};
        case (adr)
            7'd5:    entry = '{patch: 1'b1, last: 1'b0, word: 32'hE3A0_0000};
            7'd6:    entry = '{patch: 1'b0, last: 1'b1, word: 32'hE52D_0004};
            7'd9:    entry = '{patch: 1'b0, last: 1'b1, word: 32'hE1A0_0000};
            7'd120, 7'd121, 7'd122, 7'd123,
            7'd124, 7'd125, 7'd126, 7'd127:
                     entry = '{patch: 1'b0, last: 1'b0, word: 32'hE1A0_0000};
            default: entry = '{patch: 1'b0, last: 1'b0, word: 32'h0000_0000};
        endcase
    end

endmodule

// File: rtl/inst_template_emitter.sv
// inst_template_emitter: walks an ARM instruction template from the
// template ROM, patches the bytecode operand into marked immediates and
// streams the words to the code buffer over valid/ready.
module inst_template_emitter #(
    parameter int ADR_W   = 7,
    parameter int WORD_W  = 32,
    parameter int MAX_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adr_valid,
    output logic              adr_ready,
    input  logic [ADR_W-1:0]  adr,
    input  logic [7:0]        operand,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              out_last,
    output logic              err,
    output logic              busy
);
    import jit_pkg::*;

    localparam int CNT_W = $clog2(MAX_LEN) + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADR_W-1:0]    r_ptr;
    logic [ADR_W-1:0]    w_ptr_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [7:0]          r_operand;
    logic [7:0]          w_operand_nxt;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic [WORD_W-1:0]   r_out_word;
    logic [WORD_W-1:0]   w_out_word_nxt;
    logic                r_out_last;
    logic                w_out_last_nxt;
    logic                r_err;
    logic                w_err_nxt;

    logic [ADR_W-1:0]    w_rom_adr;
    tmpl_entry_t         w_rom_entry;

    logic                w_accept;
    logic                w_unsup;
    logic                w_xfer;
    logic                w_done;
    logic                w_abort;

    // Request and transfer qualifiers
    assign w_accept = (r_state == IDLE) && adr_valid && (adr != {ADR_W{1'b0}});
    assign w_unsup  = (r_state == IDLE) && adr_valid && (adr == {ADR_W{1'b0}});
    assign w_xfer   = (r_state == EMIT) && r_out_valid && out_ready;
    assign w_done   = w_xfer && r_out_last;
    assign w_abort  = w_xfer && !r_out_last &&
                      ((r_cnt == CNT_W'(MAX_LEN)) || (r_ptr == {ADR_W{1'b0}}));

    // ROM reads the start address while idle and the walk pointer while emitting
    always_comb begin
        w_rom_adr = r_ptr;
        if (r_state == IDLE) begin
            w_rom_adr = adr;
        end else begin
            w_rom_adr = r_ptr;
        end
    end

    inst_template_rom u_rom (
        .adr   (w_rom_adr),
        .entry (w_rom_entry)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = EMIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EMIT: begin
                if (w_done || w_abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = EMIT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs; hold by default
    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_operand_nxt   = r_operand;
        w_out_valid_nxt = r_out_valid;
        w_out_word_nxt  = r_out_word;
        w_out_last_nxt  = r_out_last;
        w_err_nxt       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_operand_nxt   = operand;
                    w_ptr_nxt       = adr + ADR_W'(1);
                    w_cnt_nxt       = CNT_W'(1);
                    w_out_valid_nxt = 1'b1;
                    w_out_word_nxt  = patch_imm(w_rom_entry.word, operand, w_rom_entry.patch);
                    w_out_last_nxt  = w_rom_entry.last;
                end else if (w_unsup) begin
                    w_err_nxt       = 1'b1;
                    w_out_valid_nxt = 1'b0;
                end else begin
                    w_out_valid_nxt = 1'b0;
                end
            end
            EMIT: begin
                if (w_done) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_word_nxt  = {WORD_W{1'b0}};
                    w_out_last_nxt  = 1'b0;
                end else if (w_abort) begin
                    w_err_nxt       = 1'b1;
                    w_out_valid_nxt = 1'b0;
                    w_out_word_nxt  = {WORD_W{1'b0}};
                    w_out_last_nxt  = 1'b0;
                end else if (w_xfer) begin
                    w_ptr_nxt       = r_ptr + ADR_W'(1);
                    w_cnt_nxt       = r_cnt + CNT_W'(1);
                    w_out_word_nxt  = patch_imm(w_rom_entry.word, r_operand, w_rom_entry.patch);
                    w_out_last_nxt  = w_rom_entry.last;
                end else begin
                    w_out_valid_nxt = r_out_valid;
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset drops any partial template
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= {ADR_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_operand   <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_word  <= {WORD_W{1'b0}};
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_operand   <= w_operand_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_word  <= w_out_word_nxt;
            r_out_last  <= w_out_last_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign adr_ready = (r_state == IDLE);
    assign busy      = (r_state == EMIT);
    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_last  = r_out_last;
    assign err       = r_err;

endmodule

// File: tb/tb_inst_template_emitter.sv
// Self-checking bench for inst_template_emitter with a scoreboard of
// expected {last, word} pairs built from the stub template image.
module tb_inst_template_emitter;

    logic        clk;
    logic        rst;
    logic        adr_valid;
    logic        adr_ready;
    logic [6:0]  adr;
    logic [7:0]  operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;
    logic        err;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [32:0] sb_q[$];

    inst_template_emitter #(.ADR_W(7), .WORD_W(32), .MAX_LEN(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .adr_valid (adr_valid),
        .adr_ready (adr_ready),
        .adr       (adr),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub image as {patch, last, word}
    function automatic logic [33:0] model_entry(input logic [6:0] a);
        if (a == 7'd5)        return {1'b1, 1'b0, 32'hE3A00000};
        else if (a == 7'd6)   return {1'b0, 1'b1, 32'hE52D0004};
        else if (a == 7'd9)   return {1'b0, 1'b1, 32'hE1A00000};
        else if (a >= 7'd120) return {1'b0, 1'b0, 32'hE1A00000};
        else                  return 34'd0;
    endfunction

    // Walk the template in the model and queue expected words
    task automatic push_expected(input logic [6:0] a, input logic [7:0] op, output bit exp_err);
        logic [6:0]  p;
        logic [33:0] e;
        logic [31:0] w;
        int          n;
        p = a; n = 0; exp_err = 1'b0;
        if (a == 7'd0) begin
            exp_err = 1'b1;
        end else begin
            forever begin
                e = model_entry(p);
                w = e[31:0];
                if (e[33]) w[7:0] = op;
                sb_q.push_back({e[32], w});
                n++;
                if (e[32]) break;
                p = p + 7'd1;
                if (n == 16 || p == 7'd0) begin
                    exp_err = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++; if (out_word !== 32'h0) begin tests_failed++; $display("FAIL reset_out_word: got %h want 0", out_word); end
        tests_run++; if (out_last !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got last=%b err=%b busy=%b want 000", out_last, err, busy); end
        tests_run++; if (adr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_adr_ready: got %b want 1", adr_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (adr_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle: got ready=%b valid=%b want 1 0", adr_ready, out_valid); end
    endtask

    task automatic test_patched();
        logic [32:0] exp;
        bit          exp_err;
        int          cyc;
        @(negedge clk);
        out_ready = 1'b1; adr = 7'd5; operand = 8'h2A; adr_valid = 1'b1;
        push_expected(adr, operand, exp_err);
        @(negedge clk);
        adr_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || busy !== 1'b1 || adr_ready !== 1'b0) begin tests_failed++; $display("FAIL patched_first_latency: got valid=%b busy=%b ready=%b want 1 1 0", out_valid, busy, adr_ready); end
        cyc = 0;
        while (sb_q.size() > 0 && cyc < 40) begin
            if (out_valid && out_ready) begin
                exp = sb_q.pop_front();
                tests_run++; if ({out_last, out_word} !== exp) begin tests_failed++; $display("FAIL patched_word: got last=%b word=%h want last=%b word=%h", out_last, out_word, exp[32], exp[31:0]); end
            end
            tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL patched_err: got %b want 0", err); end
            @(negedge clk); cyc++;
        end
        if (sb_q.size() > 0) begin tests_run++; tests_failed++; $display("FAIL patched_timeout: got %0d words left want 0", sb_q.size()); sb_q.delete(); end
        tests_run++; if (cyc !== 2 || adr_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL patched_done: got cyc=%0d ready=%b valid=%b want 2 1 0", cyc, adr_ready, out_valid); end
        tests_run++; if (err !== exp_err) begin tests_failed++; $display("FAIL patched_end_err: got %b want %b", err, exp_err); end
    endtask

    task automatic test_single();
        logic [32:0] exp;
        bit          exp_err;
        int          cyc;
        @(negedge clk);
        out_ready = 1'b1; adr = 7'd9; operand = 8'h77; adr_valid = 1'b1;
        push_expected(adr, operand, exp_err);
        @(negedge clk);
        adr_valid = 1'b0;
        cyc = 0;
        while (sb_q.size() > 0 && cyc < 40) begin
            if (out_valid && out_ready) begin
                exp = sb_q.pop_front();
                tests_run++; if ({out_last, out_word} !== exp) begin tests_failed++; $display("FAIL single_word: got last=%b word=%h want last=%b word=%h", out_last, out_word, exp[32], exp[31:0]); end
            end
            @(negedge clk); cyc++;
        end
        if (sb_q.size() > 0) begin tests_run++; tests_failed++; $display("FAIL single_timeout: got %0d words left want 0", sb_q.size()); sb_q.delete(); end
        tests_run++; if (cyc !== 1 || adr_ready !== 1'b1 || err !== exp_err) begin tests_failed++; $display("FAIL single_done: got cyc=%0d ready=%b err=%b want 1 1 %b", cyc, adr_ready, err, exp_err); end
        @(negedge clk);
        tests_run++; if (err !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_after: got err=%b valid=%b want 0 0", err, out_valid); end
    endtask

    task automatic test_unsupported();
        bit exp_err;
        @(negedge clk);
        adr = 7'd0; operand = 8'h55; adr_valid = 1'b1;
        push_expected(adr, operand, exp_err);
        @(negedge clk);
        adr_valid = 1'b0;
        tests_run++; if (err !== exp_err) begin tests_failed++; $display("FAIL unsup_err: got %b want %b", err, exp_err); end
        tests_run++; if (out_valid !== 1'b0 || adr_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL unsup_state: got valid=%b ready=%b busy=%b want 0 1 0", out_valid, adr_ready, busy); end
        @(negedge clk);
        tests_run++; if (err !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL unsup_pulse: got err=%b valid=%b want 0 0", err, out_valid); end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp;
        bit          exp_err;
        int          cyc;
        @(negedge clk);
        out_ready = 1'b0; adr = 7'd5; operand = 8'hC3; adr_valid = 1'b1;
        push_expected(adr, operand, exp_err);
        @(negedge clk);
        adr_valid = 1'b0;
        cyc = 0;
        while (sb_q.size() > 0 && cyc < 40) begin
            out_ready = (cyc >= 3);
            if (out_valid && !out_ready) begin
                tests_run++; if ({out_last, out_word} !== sb_q[0]) begin tests_failed++; $display("FAIL bp_hold: got last=%b word=%h want last=%b word=%h", out_last, out_word, sb_q[0][32], sb_q[0][31:0]); end
            end else if (out_valid && out_ready) begin
                exp = sb_q.pop_front();
                tests_run++; if ({out_last, out_word} !== exp) begin tests_failed++; $display("FAIL bp_word: got last=%b word=%h want last=%b word=%h", out_last, out_word, exp[32], exp[31:0]); end
            end else begin
                tests_run++; tests_failed++; $display("FAIL bp_valid: got valid=%b want 1 at cycle %0d", out_valid, cyc);
            end
            @(negedge clk); cyc++;
        end
        if (sb_q.size() > 0) begin tests_run++; tests_failed++; $display("FAIL bp_timeout: got %0d words left want 0", sb_q.size()); sb_q.delete(); end
        tests_run++; if (cyc !== 5 || adr_ready !== 1'b1 || err !== exp_err) begin tests_failed++; $display("FAIL bp_done: got cyc=%0d ready=%b err=%b want 5 1 %b", cyc, adr_ready, err, exp_err); end
        out_ready = 1'b1;
    endtask

    task automatic test_wrap();
        logic [32:0] exp;
        bit          exp_err;
        int          cyc;
        @(negedge clk);
        out_ready = 1'b1; adr = 7'd120; operand = 8'h99; adr_valid = 1'b1;
        push_expected(adr, operand, exp_err);
        @(negedge clk);
        adr_valid = 1'b0;
        cyc = 0;
        while (sb_q.size() > 0 && cyc < 40) begin
            if (out_valid && out_ready) begin
                exp = sb_q.pop_front();
                tests_run++; if ({out_last, out_word} !== exp) begin tests_failed++; $display("FAIL wrap_word: got last=%b word=%h want last=%b word=%h", out_last, out_word, exp[32], exp[31:0]); end
            end
            tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL wrap_early_err: got %b want 0 at cycle %0d", err, cyc); end
            @(negedge clk); cyc++;
        end
        if (sb_q.size() > 0) begin tests_run++; tests_failed++; $display("FAIL wrap_timeout: got %0d words left want 0", sb_q.size()); sb_q.delete(); end
        tests_run++; if (cyc !== 8 || err !== exp_err) begin tests_failed++; $display("FAIL wrap_err: got cyc=%0d err=%b want 8 %b", cyc, err, exp_err); end
        tests_run++; if (out_valid !== 1'b0 || out_last !== 1'b0 || adr_ready !== 1'b1) begin tests_failed++; $display("FAIL wrap_idle: got valid=%b last=%b ready=%b want 0 0 1", out_valid, out_last, adr_ready); end
        @(negedge clk);
        tests_run++; if (err !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_pulse: got err=%b valid=%b want 0 0", err, out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [32:0] exp;
        bit          exp_err;
        @(negedge clk);
        out_ready = 1'b1; adr = 7'd5; operand = 8'h11; adr_valid = 1'b1;
        push_expected(adr, operand, exp_err);
        @(negedge clk);
        adr_valid = 1'b0;
        exp = sb_q.pop_front();
        tests_run++; if (out_valid !== 1'b1 || {out_last, out_word} !== exp) begin tests_failed++; $display("FAIL rmid_word0: got valid=%b word=%h want 1 %h", out_valid, out_word, exp[31:0]); end
        @(negedge clk);
        tests_run++; if (out_valid !== 1'b1 || {out_last, out_word} !== sb_q[0]) begin tests_failed++; $display("FAIL rmid_word1: got valid=%b word=%h want 1 %h", out_valid, out_word, sb_q[0][31:0]); end
        #1 rst = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0 || out_word !== 32'h0 || out_last !== 1'b0) begin tests_failed++; $display("FAIL rmid_async: got valid=%b word=%h last=%b want 0 0 0", out_valid, out_word, out_last); end
        tests_run++; if (adr_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_state: got ready=%b busy=%b want 1 0", adr_ready, busy); end
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (adr_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_release: got ready=%b valid=%b want 1 0", adr_ready, out_valid); end
        test_single();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; adr_valid = 1'b0; adr = 7'd0; operand = 8'h00; out_ready = 1'b0;
        test_reset();
        test_patched();
        test_single();
        test_unsupported();
        test_backpressure();
        test_patched();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
